// File: rtl/stopwatch_uart_reporter_pkg.sv
// Shared constants for the stopwatch UART reporter: ASCII codes, FSM encodings
// and the payload byte selection used by the top-level reporter.
package stopwatch_uart_reporter_pkg;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;

  // Byte transmitter states
  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

  // Reporter states
  localparam logic [0:0] RP_IDLE = 1'b0;
  localparam logic [0:0] RP_SEND = 1'b1;

  // Non-BCD digits become '?' so a corrupted digit is visible on the terminal.
  function automatic logic [7:0] digit_to_ascii(input logic [3:0] d);
    if (d > 4'd9) return ASCII_QMARK;
    return {ASCII_ZERO[7:4], d};
  endfunction

  function automatic logic [7:0] payload_byte(input logic [1:0] idx,
                                              input logic [3:0] tens,
                                              input logic [3:0] ones);
    case (idx)
      2'd0:    return digit_to_ascii(tens);
      2'd1:    return digit_to_ascii(ones);
      2'd2:    return ASCII_CR;
      default: return ASCII_LF;
    endcase
  endfunction

endpackage

// File: rtl/stopwatch_uart_reporter_uart_tx_byte.sv
// 8N1 byte transmitter, LSB first. valid/ready handshake: a byte is taken on a
// cycle where valid & ready; ready is high in IDLE and on the last STOP cycle.
module uart_tx_byte
  import stopwatch_uart_reporter_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_tx;

  logic w_bit_end;
  logic w_accept;

  assign w_bit_end = (r_cnt == LAST_CNT);
  assign ready     = (r_state == TX_IDLE) || ((r_state == TX_STOP) && w_bit_end);
  assign w_accept  = valid && ready;
  assign tx        = r_tx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= TX_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else if (w_accept) begin
      // Taking a byte from the last STOP cycle gives back-to-back frames.
      r_state <= TX_START;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= data;
      r_tx    <= 1'b0;
    end else begin
      case (r_state)
        TX_START: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_state <= TX_DATA;
            r_tx    <= r_shift[0];
          end else begin
            r_cnt <= r_cnt + ONE_CNT;
          end
        end
        TX_DATA: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_bit == 3'd7) begin
              r_state <= TX_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_shift <= {1'b0, r_shift[7:1]};
              r_tx    <= r_shift[1];
            end
          end else begin
            r_cnt <= r_cnt + ONE_CNT;
          end
        end
        TX_STOP: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_state <= TX_IDLE;
          end else begin
            r_cnt <= r_cnt + ONE_CNT;
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= TX_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/stopwatch_uart_reporter.sv
// Sends the two stopwatch digits as "TU\r\n" over 8N1 UART on each send pulse;
// requests arriving while a report is in flight are dropped and flagged.
module stopwatch_uart_reporter
  import stopwatch_uart_reporter_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD        = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send,
  input  logic [3:0] digit_tens,
  input  logic [3:0] digit_ones,
  output logic       usb_tx,
  output logic       busy,
  output logic       dropped
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;

  logic [0:0] r_state;
  logic [1:0] r_idx;
  logic [3:0] r_tens;
  logic [3:0] r_ones;
  logic       r_dropped;

  logic       w_accept;
  logic       w_valid;
  logic       w_ready;
  logic [1:0] w_next_idx;
  logic [7:0] w_data;

  assign w_accept   = (r_state == RP_IDLE) && send;
  assign w_next_idx = r_idx + 2'd1;

  // The first byte goes straight from the live inputs so the start bit
  // appears one cycle after send; later bytes come from the latched digits.
  assign w_valid = w_accept || ((r_state == RP_SEND) && (r_idx != 2'd3));
  assign w_data  = (r_state == RP_IDLE) ? payload_byte(2'd0, digit_tens, digit_ones)
                                        : payload_byte(w_next_idx, r_tens, r_ones);

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk  (clk),
    .rst  (rst),
    .data (w_data),
    .valid(w_valid),
    .ready(w_ready),
    .tx   (usb_tx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= RP_IDLE;
      r_idx     <= '0;
      r_tens    <= '0;
      r_ones    <= '0;
      r_dropped <= 1'b0;
    end else begin
      r_dropped <= send && (r_state == RP_SEND);
      case (r_state)
        RP_IDLE: begin
          if (send) begin
            r_state <= RP_SEND;
            r_idx   <= '0;
            r_tens  <= digit_tens;
            r_ones  <= digit_ones;
          end
        end
        default: begin
          // r_idx is the byte on the wire; ready marks its final stop cycle.
          if (w_ready) begin
            if (r_idx == 2'd3) begin
              r_state <= RP_IDLE;
              r_idx   <= '0;
            end else begin
              r_idx <= w_next_idx;
            end
          end
        end
      endcase
    end
  end

  assign busy    = (r_state == RP_SEND);
  assign dropped = r_dropped;

endmodule
